press_detector: RTL
===================

PRESS_DETECTOR -- requirements
Module: press_detector

Interface
REQ-001 Parameter LONG_COUNT, default 40000000, hold cycles from press to long-press recognition (1 s at 40 MHz); legal range 2..2^26-1.
REQ-002 Parameter REPEAT_COUNT, default 10000000, cycles between auto-repeat pulses while long-held (250 ms at 40 MHz); legal range 2..2^26-1.
REQ-003 clk  input  1  system clock, 40 MHz, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 inButton  input  1  debounced button level (debouncer outButton), 1 = pressed, synchronous to clk.
REQ-006 pressPulse  output  1  one-cycle strobe on recognized press.
REQ-007 longPulse  output  1  one-cycle strobe when hold reaches LONG_COUNT.
REQ-008 repeatPulse  output  1  one-cycle strobe every REPEAT_COUNT cycles after longPulse while held.
REQ-009 releasePulse  output  1  one-cycle strobe on recognized release.
REQ-010 wasLong  output  1  valid with releasePulse: 1 = released after longPulse, 0 = short press.
REQ-011 held  output  1  level, 1 while FSM is in SHORT or LONG.
REQ-012 pressCount  output  8  count of recognized presses, saturating at 255.

Function
REQ-013 One register prevBtn shall hold the previous-cycle inButton sample; rise = inButton & ~prevBtn, fall = ~inButton & prevBtn.
REQ-014 FSM states IDLE, SHORT, LONG; all outputs registered, no combinational input-to-output path.
REQ-015 IDLE: on rise -> SHORT, pressPulse=1 next cycle, holdCnt cleared to 0, pressCount += 1 unless already 255.
REQ-016 SHORT: holdCnt increments each cycle; pressPulse-to-longPulse distance shall be exactly LONG_COUNT cycles; at that point -> LONG, longPulse=1, repCnt cleared to 0.
REQ-017 LONG: repCnt increments each cycle; repeatPulse asserted exactly REPEAT_COUNT cycles after longPulse and every REPEAT_COUNT cycles thereafter; repCnt wraps to 0 on each repeatPulse.
REQ-018 SHORT or LONG: on fall -> IDLE, releasePulse=1 next cycle, wasLong = (state was LONG); counters cleared.
REQ-019 Fall in the same cycle as long threshold: release wins -> IDLE, releasePulse=1, wasLong=0, no longPulse.
REQ-020 Fall in the same cycle as repeat threshold: release wins, no repeatPulse.
REQ-021 At most one of pressPulse, longPulse, repeatPulse, releasePulse high in any cycle.
REQ-022 wasLong shall hold its value until next releasePulse; only meaningful when releasePulse=1.
REQ-023 holdCnt, repCnt 26 bits wide; no wrap possible within legal parameter range.
REQ-024 pressCount shall remain 255 on further presses; no wrap to 0.

Reset
REQ-025 reset=1 at a rising edge: state=IDLE, all pulses 0, held=0, wasLong=0, pressCount=0, counters 0, prevBtn=1.
REQ-026 prevBtn=1 after reset: button held through reset shall not produce pressPulse until released and pressed again; that release shall produce no releasePulse.
REQ-027 Reset mid-SHORT or mid-LONG: abort silently, no releasePulse, no pending pulses emitted after reset deasserts.
REQ-028 reset has priority over all inputs in the same cycle.

Verification (LONG_COUNT=4, REPEAT_COUNT=2)
REQ-029 Reset, inButton=0, then high for 2 cycles, low -> pressPulse 1 cycle, releasePulse 1 cycle with wasLong=0, pressCount=1, no longPulse.
REQ-030 inButton high for 10 cycles -> pressPulse, longPulse 4 cycles later, repeatPulse at +2 and +4 after longPulse, then releasePulse with wasLong=1.
REQ-031 Release timed on long-threshold cycle -> releasePulse, wasLong=0, longPulse never asserted.
REQ-032 inButton=1 held across reset deassertion -> no pressPulse, no releasePulse on later release; next press counted normally.
REQ-033 Reset asserted 2 cycles into LONG -> all outputs 0, held=0, pressCount=0 next cycle, no releasePulse after.
REQ-034 260 short presses -> pressCount stops at 255; one-hot pulse check (REQ-021) holds throughout.

Source files
------------

// File: rtl/press_detector_if.sv
// Button-level input and press-event outputs of press_detector.
// The master side drives the debounced button; the slave side is the detector.
interface press_detector_if;
    logic       inButton;
    logic       pressPulse;
    logic       longPulse;
    logic       repeatPulse;
    logic       releasePulse;
    logic       wasLong;
    logic       held;
    logic [7:0] pressCount;

    modport master (
        output inButton,
        input  pressPulse,
        input  longPulse,
        input  repeatPulse,
        input  releasePulse,
        input  wasLong,
        input  held,
        input  pressCount
    );

    modport slave (
        input  inButton,
        output pressPulse,
        output longPulse,
        output repeatPulse,
        output releasePulse,
        output wasLong,
        output held,
        output pressCount
    );
endinterface

// File: rtl/press_detector.sv
// Press / long-press / auto-repeat / release detector for a debounced button.
// All outputs are registered; release always wins over a coincident long or repeat threshold.
module press_detector #(
    parameter int unsigned LONG_COUNT   = 40000000,
    parameter int unsigned REPEAT_COUNT = 10000000
) (
    input  logic             clk,
    input  logic             reset,
    press_detector_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHORT = 2'd1;
    localparam logic [1:0] ST_LONG  = 2'd2;

    // Counters start at 0 on the cycle a pulse is issued, so the threshold is COUNT-1.
    localparam logic [25:0] LONG_LAST   = 26'(LONG_COUNT - 32'd1);
    localparam logic [25:0] REPEAT_LAST = 26'(REPEAT_COUNT - 32'd1);

    logic        prev_btn_r;
    logic [1:0]  state_r;
    logic [25:0] hold_cnt_r;
    logic [25:0] rep_cnt_r;
    logic        press_pulse_r;
    logic        long_pulse_r;
    logic        repeat_pulse_r;
    logic        release_pulse_r;
    logic        was_long_r;
    logic        held_r;
    logic [7:0]  press_count_r;

    logic        rise_s;
    logic        fall_s;
    logic [1:0]  state_nxt_s;
    logic [25:0] hold_cnt_nxt_s;
    logic [25:0] rep_cnt_nxt_s;
    logic        press_pulse_nxt_s;
    logic        long_pulse_nxt_s;
    logic        repeat_pulse_nxt_s;
    logic        release_pulse_nxt_s;
    logic        was_long_nxt_s;
    logic        held_nxt_s;
    logic [7:0]  press_count_nxt_s;

    assign rise_s = bus.inButton & ~prev_btn_r;
    assign fall_s = ~bus.inButton & prev_btn_r;

    // Next-state and next-output decode for the press FSM.
    always_comb begin
        state_nxt_s         = state_r;
        hold_cnt_nxt_s      = hold_cnt_r;
        rep_cnt_nxt_s       = rep_cnt_r;
        press_pulse_nxt_s   = 1'b0;
        long_pulse_nxt_s    = 1'b0;
        repeat_pulse_nxt_s  = 1'b0;
        release_pulse_nxt_s = 1'b0;
        was_long_nxt_s      = was_long_r;
        press_count_nxt_s   = press_count_r;

        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_nxt_s       = ST_SHORT;
                    press_pulse_nxt_s = 1'b1;
                    hold_cnt_nxt_s    = 26'd0;
                    rep_cnt_nxt_s     = 26'd0;
                    if (press_count_r != 8'd255) begin
                        press_count_nxt_s = press_count_r + 8'd1;
                    end else begin
                        press_count_nxt_s = press_count_r;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_SHORT: begin
                if (fall_s) begin
                    state_nxt_s         = ST_IDLE;
                    release_pulse_nxt_s = 1'b1;
                    was_long_nxt_s      = 1'b0;
                    hold_cnt_nxt_s      = 26'd0;
                    rep_cnt_nxt_s       = 26'd0;
                end else if (hold_cnt_r == LONG_LAST) begin
                    state_nxt_s      = ST_LONG;
                    long_pulse_nxt_s = 1'b1;
                    hold_cnt_nxt_s   = 26'd0;
                    rep_cnt_nxt_s    = 26'd0;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + 26'd1;
                end
            end

            ST_LONG: begin
                if (fall_s) begin
                    state_nxt_s         = ST_IDLE;
                    release_pulse_nxt_s = 1'b1;
                    was_long_nxt_s      = 1'b1;
                    hold_cnt_nxt_s      = 26'd0;
                    rep_cnt_nxt_s       = 26'd0;
                end else if (rep_cnt_r == REPEAT_LAST) begin
                    repeat_pulse_nxt_s = 1'b1;
                    rep_cnt_nxt_s      = 26'd0;
                end else begin
                    rep_cnt_nxt_s = rep_cnt_r + 26'd1;
                end
            end

            default: begin
                // Unreachable encoding: fall back to IDLE without emitting anything.
                state_nxt_s    = ST_IDLE;
                hold_cnt_nxt_s = 26'd0;
                rep_cnt_nxt_s  = 26'd0;
            end
        endcase

        held_nxt_s = (state_nxt_s == ST_SHORT) || (state_nxt_s == ST_LONG);
    end

    // State, counter and output registers; reset aborts any press silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_btn_r      <= 1'b1;
            state_r         <= ST_IDLE;
            hold_cnt_r      <= 26'd0;
            rep_cnt_r       <= 26'd0;
            press_pulse_r   <= 1'b0;
            long_pulse_r    <= 1'b0;
            repeat_pulse_r  <= 1'b0;
            release_pulse_r <= 1'b0;
            was_long_r      <= 1'b0;
            held_r          <= 1'b0;
            press_count_r   <= 8'd0;
        end else begin
            prev_btn_r      <= bus.inButton;
            state_r         <= state_nxt_s;
            hold_cnt_r      <= hold_cnt_nxt_s;
            rep_cnt_r       <= rep_cnt_nxt_s;
            press_pulse_r   <= press_pulse_nxt_s;
            long_pulse_r    <= long_pulse_nxt_s;
            repeat_pulse_r  <= repeat_pulse_nxt_s;
            release_pulse_r <= release_pulse_nxt_s;
            was_long_r      <= was_long_nxt_s;
            held_r          <= held_nxt_s;
            press_count_r   <= press_count_nxt_s;
        end
    end

    assign bus.pressPulse   = press_pulse_r;
    assign bus.longPulse    = long_pulse_r;
    assign bus.repeatPulse  = repeat_pulse_r;
    assign bus.releasePulse = release_pulse_r;
    assign bus.wasLong      = was_long_r;
    assign bus.held         = held_r;
    assign bus.pressCount   = press_count_r;

endmodule
